multi_nch_disp: RTL and testbench

MULTI_NCH_DISP -- requirements
Module: multi_nch_disp

---
 rtl/multi_nch_disp.sv | 97 +++++++++
 tb/tb_multi_nch_disp.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multi_nch_disp.sv
// multi_nch_disp: multi-channel display selector with registered outputs and optional timed auto-scan.
// Define MULTI_NCH_SCAN_EN to compile in the auto-scan logic; without it the block is manual-select only.
module multi_nch_disp #(
   parameter int CH_NUM = 8,
   parameter int DW     = 32,
   parameter int SEL_W  = 3,
   parameter int DWELL  = 50000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 EN,
   input  logic [SEL_W-1:0]     Test,
   input  logic                 auto_scan,
   input  logic [CH_NUM*8-1:0]  point_in,
   input  logic [CH_NUM*8-1:0]  LES,
   input  logic [DW-1:0]        Data0,
   input  logic [CH_NUM*DW-1:0] data_in,
   output logic [7:0]           point_out,
   output logic [7:0]           LE_out,
   output logic [DW-1:0]        Disp_num,
   output logic [SEL_W-1:0]     ch_idx
);
   logic [DW-1:0]    d0_reg;
   logic [SEL_W-1:0] sel;
   logic [DW-1:0]    nx_data;
   logic [7:0]       nx_pt, nx_le;
   logic             unused_ok;

   always_ff @(posedge clk)
      if (rst) d0_reg <= '0;
      else if (EN) d0_reg <= Data0;

`ifdef MULTI_NCH_SCAN_EN
   localparam int CW = $clog2(DWELL);
   typedef enum logic {MANUAL, SCAN} state_t;
   state_t           state, nx_state;
   logic [CW-1:0]    dcnt;
   logic [SEL_W-1:0] sidx;
   logic             test_ok;

   assign test_ok = {1'b0, Test} < (SEL_W+1)'(CH_NUM);

   always_ff @(posedge clk)
      if (rst) state <= MANUAL;
      else state <= nx_state;

   always_comb nx_state = auto_scan ? SCAN : MANUAL;

   always_comb sel = (state == SCAN) ? sidx : Test;

   // dcnt stays at 0 whenever not scanning, so a new scan always starts a full dwell
   always_ff @(posedge clk)
      if (rst) begin
         dcnt <= '0;
         sidx <= '0;
      end else if (state == MANUAL) begin
         dcnt <= '0;
         if (auto_scan) sidx <= test_ok ? Test : '0;
      end else if (!auto_scan) dcnt <= '0;
      else if (dcnt == CW'(DWELL-1)) begin
         dcnt <= '0;
         sidx <= (sidx == SEL_W'(CH_NUM-1)) ? '0 : sidx + SEL_W'(1);
      end else dcnt <= dcnt + CW'(1);

   assign unused_ok = ^data_in[DW-1:0];
`else
   always_comb sel = Test;

   assign unused_ok = ^{data_in[DW-1:0], auto_scan};
`endif

   // out-of-range selects match no channel and leave the zero defaults
   always_comb begin
      nx_data = '0;
      nx_pt   = '0;
      nx_le   = '0;
      for (int k = 0; k < CH_NUM; k++)
         if (sel == SEL_W'(k)) begin
            nx_data = (k == 0) ? d0_reg : data_in[k*DW +: DW];
            nx_pt   = point_in[k*8 +: 8];
            nx_le   = LES[k*8 +: 8];
         end
   end

   always_ff @(posedge clk)
      if (rst) begin
         Disp_num  <= '0;
         point_out <= '0;
         LE_out    <= '0;
         ch_idx    <= '0;
      end else begin
         Disp_num  <= nx_data;
         point_out <= nx_pt;
         LE_out    <= nx_le;
         ch_idx    <= sel;
      end
endmodule

// File: tb/tb_multi_nch_disp.sv
// tb_multi_nch_disp: directed table-driven bench for multi_nch_disp (CH_NUM=6, DWELL=4).
module tb_multi_nch_disp;
   localparam int CH_NUM = 6;
   localparam int DW     = 32;
   localparam int SEL_W  = 3;
   localparam int DWELL  = 4;

   logic                 clk = 0;
   logic                 rst, EN, auto_scan;
   logic [SEL_W-1:0]     Test;
   logic [CH_NUM*8-1:0]  point_in, LES;
   logic [DW-1:0]        Data0;
   logic [CH_NUM*DW-1:0] data_in;
   logic [7:0]           point_out, LE_out;
   logic [DW-1:0]        Disp_num;
   logic [SEL_W-1:0]     ch_idx;

   int tests = 0;
   int fails = 0;

   multi_nch_disp #(.CH_NUM(CH_NUM), .DW(DW), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .EN(EN), .Test(Test), .auto_scan(auto_scan),
      .point_in(point_in), .LES(LES), .Data0(Data0), .data_in(data_in),
      .point_out(point_out), .LE_out(LE_out), .Disp_num(Disp_num), .ch_idx(ch_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SEL_W-1:0] test;
      logic [DW-1:0]    disp;
      logic [7:0]       pt;
      logic [7:0]       le;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [DW-1:0] d, input logic [7:0] p,
                          input logic [7:0] l, input logic [SEL_W-1:0] i);
      chk({nm, ".disp"}, Disp_num, d);
      chk({nm, ".pt"}, 32'(point_out), 32'(p));
      chk({nm, ".le"}, 32'(LE_out), 32'(l));
      chk({nm, ".idx"}, 32'(ch_idx), 32'(i));
   endtask

   initial begin
      vecs[0] = '{3'd0, 32'h0000_0000, 8'h01, 8'hA0};
      vecs[1] = '{3'd1, 32'h1111_1111, 8'h02, 8'hA1};
      vecs[2] = '{3'd2, 32'h2222_2222, 8'h04, 8'hA2};
      vecs[3] = '{3'd3, 32'hDEAD_BEEF, 8'h0F, 8'hA3};
      vecs[4] = '{3'd4, 32'h4444_4444, 8'h10, 8'hA4};
      vecs[5] = '{3'd5, 32'h5555_5555, 8'h20, 8'hA5};
      vecs[6] = '{3'd6, 32'h0000_0000, 8'h00, 8'h00};
      vecs[7] = '{3'd7, 32'h0000_0000, 8'h00, 8'h00};

      data_in  = {32'h5555_5555, 32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111, 32'hFFFF_FFFF};
      point_in = {8'h20, 8'h10, 8'h0F, 8'h04, 8'h02, 8'h01};
      LES      = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
      Data0 = 32'h0BAD_0BAD;
      EN = 1;
      auto_scan = 0;
      Test = 3'd3;

      // reset wins over EN on the same edge
      rst = 1;
      step();
      step();
      chk_all("reset", 32'h0, 8'h00, 8'h00, 3'd0);
      rst = 0;
      EN = 0;
      Test = 3'd0;
      step();
      chk_all("post_reset", 32'h0, 8'h01, 8'hA0, 3'd0);

      for (int i = 0; i < 8; i++) begin
         Test = vecs[i].test;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].pt, vecs[i].le, vecs[i].test);
      end

      // registered output: a select change is not visible before the edge
      Test = 3'd1;
      #2;
      chk("latency.before", 32'(ch_idx), 32'd7);
      step();
      chk("latency.after", Disp_num, 32'h1111_1111);
      data_in[2*DW-1:DW] = 32'hCAFE_0001;
      #2;
      chk("live.before", Disp_num, 32'h1111_1111);
      step();
      chk("live.after", Disp_num, 32'hCAFE_0001);

      // EN write to the selected channel 0 shows with one extra cycle
      Test = 3'd0;
      step();
      Data0 = 32'h1234_5678;
      EN = 1;
      step();
      chk("en.edge_k", Disp_num, 32'h0);
      EN = 0;
      Data0 = 32'h0BAD_0BAD;
      step();
      chk("en.edge_k1", Disp_num, 32'h1234_5678);
      step();
      chk("en.hold", Disp_num, 32'h1234_5678);

      // write while another channel is shown
      Test = 3'd2;
      Data0 = 32'h0000_ABCD;
      EN = 1;
      step();
      EN = 0;
      chk("en.other", Disp_num, 32'h2222_2222);
      Test = 3'd0;
      step();
      chk("en.readback", Disp_num, 32'h0000_ABCD);

      // reset clears d0_reg
      rst = 1;
      step();
      rst = 0;
      step();
      chk("rst.d0", Disp_num, 32'h0);

`ifdef MULTI_NCH_SCAN_EN
      Test = 3'd4;
      auto_scan = 1;
      step();
      chk("scan.entry", 32'(ch_idx), 32'd4);
      Test = 3'd1;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk($sformatf("scan.seq%0d", i), 32'(ch_idx), (i <= 4) ? 32'd4 : (i <= 8) ? 32'd5 : 32'd0);
      end
      step();
      rst = 1;
      auto_scan = 0;
      Test = 3'd3;
      step();
      chk("scan.rst", 32'(ch_idx), 32'd0);
      rst = 0;
      step();
      chk("scan.manual", 32'(ch_idx), 32'd3);
`else
      Test = 3'd2;
      auto_scan = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("noscan%0d", i), 32'(ch_idx), 32'd2);
      end
      auto_scan = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
